// File: rtl/ddr_global_pkg.sv
// Shared constants and helpers for the DDR datapath FIFO blocks.
package ddr_global_pkg;

  localparam int unsigned DDR_FIFO_MIN_DEPTH = 4;

  // True when n is a non-zero power of two.
  function automatic bit ddr_is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/ddr_fifo_loop_ptr.sv
// FIFO pointer: binary increment with wrap bit, or windowed replay between start and stop.
module ddr_fifo_loop_ptr #(
  parameter int unsigned AWIDTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_loop_mode,
  input  logic              i_inc,
  input  logic [AWIDTH-1:0] i_start_ptr,
  input  logic [AWIDTH-1:0] i_stop_ptr,
  output logic [AWIDTH:0]   o_ptr
);

  localparam int unsigned PW = AWIDTH + 1;

  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     ptr_d;
  logic [AWIDTH-1:0] addr;

  assign addr = ptr_q[AWIDTH-1:0];

  // Clear beats load beats increment; loop mode drops the wrap bit.
  always_comb begin
    ptr_d = ptr_q;
    if (i_clr) begin
      ptr_d = '0;
    end else if (i_load) begin
      ptr_d = {1'b0, i_start_ptr};
    end else if (i_inc) begin
      if (!i_loop_mode) begin
        ptr_d = ptr_q + PW'(1);
      end else if (addr == i_stop_ptr) begin
        ptr_d = {1'b0, i_start_ptr};
      end else begin
        ptr_d = {1'b0, addr + AWIDTH'(1)};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/ddr_sync_fifo_loop.sv
// Single-clock show-ahead FIFO with a replay (loop) mode that cycles a fixed address window.
module ddr_sync_fifo_loop
  import ddr_global_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AWIDTH = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_loop_mode,
  input  logic              i_load_ptr,
  input  logic [AWIDTH-1:0] i_start_ptr,
  input  logic [AWIDTH-1:0] i_stop_ptr,
  input  logic [AWIDTH:0]   i_af_thresh,
  input  logic [AWIDTH:0]   i_ae_thresh,
  input  logic              i_write,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_read,
  input  logic              i_err_clr,
  output logic [WIDTH-1:0]  o_rdata,
  output logic              o_full,
  output logic              o_afull,
  output logic              o_empty_n,
  output logic              o_aempty,
  output logic [AWIDTH:0]   o_level,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int unsigned PW = AWIDTH + 1;

  if (DEPTH < DDR_FIFO_MIN_DEPTH || !ddr_is_pow2(DEPTH)) begin : g_bad_depth
    $error("ddr_sync_fifo_loop: DEPTH must be a power of two and at least DDR_FIFO_MIN_DEPTH");
  end

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    level;
  logic             fifo_full;
  logic             fifo_empty_n;
  logic             wr_acc;
  logic             rd_acc;
  logic             rw_ok;
  logic             mem_we;
  logic             overflow_q;
  logic             underflow_q;
  logic [WIDTH-1:0] mem [DEPTH];

  assign level        = wptr - rptr;
  assign fifo_full    = (level == PW'(DEPTH));
  assign fifo_empty_n = (level != '0);

  // Loop mode never blocks a request: the window just recirculates.
  assign wr_acc = i_write & (i_loop_mode | ~fifo_full);
  assign rd_acc = i_read  & (i_loop_mode | fifo_empty_n);
  assign rw_ok  = ~i_clr & ~i_load_ptr;
  assign mem_we = wr_acc & rw_ok;

  ddr_fifo_loop_ptr #(.AWIDTH(AWIDTH)) u_wptr (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (i_clr),
    .i_load      (i_load_ptr),
    .i_loop_mode (i_loop_mode),
    .i_inc       (wr_acc),
    .i_start_ptr (i_start_ptr),
    .i_stop_ptr  (i_stop_ptr),
    .o_ptr       (wptr)
  );

  ddr_fifo_loop_ptr #(.AWIDTH(AWIDTH)) u_rptr (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (i_clr),
    .i_load      (i_load_ptr),
    .i_loop_mode (i_loop_mode),
    .i_inc       (rd_acc),
    .i_start_ptr (i_start_ptr),
    .i_stop_ptr  (i_stop_ptr),
    .o_ptr       (rptr)
  );

  // Storage is deliberately unreset; contents survive clear and reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[wptr[AWIDTH-1:0]] <= i_wdata;
    end
  end

  // Sticky errors: only a rejected normal-mode request sets them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (i_clr || i_err_clr) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (rw_ok && !i_loop_mode) begin
      if (i_write && fifo_full) begin
        overflow_q <= 1'b1;
      end
      if (i_read && !fifo_empty_n) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign o_rdata     = mem[rptr[AWIDTH-1:0]];
  assign o_level     = i_loop_mode ? '0 : level;
  assign o_full      = ~i_loop_mode & fifo_full;
  assign o_empty_n   = i_loop_mode | fifo_empty_n;
  assign o_afull     = ~i_loop_mode & (level >= i_af_thresh);
  assign o_aempty    = ~i_loop_mode & (level <= i_ae_thresh);
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule

// File: tb/tb_ddr_sync_fifo_loop.sv
// Self-checking bench for ddr_sync_fifo_loop: vector table, scoreboard and corner sequences.
module tb_ddr_sync_fifo_loop;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_clr;
  logic        i_loop_mode;
  logic        i_load_ptr;
  logic [3:0]  i_start_ptr;
  logic [3:0]  i_stop_ptr;
  logic [4:0]  i_af_thresh;
  logic [4:0]  i_ae_thresh;
  logic        i_write;
  logic [31:0] i_wdata;
  logic        i_read;
  logic        i_err_clr;
  logic [31:0] o_rdata;
  logic        o_full;
  logic        o_afull;
  logic        o_empty_n;
  logic        o_aempty;
  logic [4:0]  o_level;
  logic        o_overflow;
  logic        o_underflow;

  ddr_sync_fifo_loop #(.WIDTH(32), .DEPTH(16)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (i_clr),
    .i_loop_mode (i_loop_mode),
    .i_load_ptr  (i_load_ptr),
    .i_start_ptr (i_start_ptr),
    .i_stop_ptr  (i_stop_ptr),
    .i_af_thresh (i_af_thresh),
    .i_ae_thresh (i_ae_thresh),
    .i_write     (i_write),
    .i_wdata     (i_wdata),
    .i_read      (i_read),
    .i_err_clr   (i_err_clr),
    .o_rdata     (o_rdata),
    .o_full      (o_full),
    .o_afull     (o_afull),
    .o_empty_n   (o_empty_n),
    .o_aempty    (o_aempty),
    .o_level     (o_level),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit wr, rd, ec, cl;
    int lvl;
    bit full, en, af, ae, ov, ud;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] sb_q[$];
  logic [31:0] loop_exp[10];
  logic [31:0] wrap_exp[5];
  int          checks;
  int          fails;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_flags(input string tag, input int lvl, input bit full, input bit en,
                           input bit af, input bit ae, input bit ov, input bit ud);
    chk($sformatf("%s.level", tag), 32'(o_level), 32'(lvl));
    chk($sformatf("%s.full", tag), 32'(o_full), 32'(full));
    chk($sformatf("%s.empty_n", tag), 32'(o_empty_n), 32'(en));
    chk($sformatf("%s.afull", tag), 32'(o_afull), 32'(af));
    chk($sformatf("%s.aempty", tag), 32'(o_aempty), 32'(ae));
    chk($sformatf("%s.overflow", tag), 32'(o_overflow), 32'(ov));
    chk($sformatf("%s.underflow", tag), 32'(o_underflow), 32'(ud));
  endtask

  // One clock of stimulus; normal-mode traffic is tracked by the scoreboard queue.
  task automatic step(input bit wr, input bit rd, input logic [31:0] d,
                      input bit ec, input bit cl, input bit ld);
    bit can_wr;
    i_write   = wr;
    i_read    = rd;
    i_wdata   = d;
    i_err_clr = ec;
    i_clr     = cl;
    i_load_ptr = ld;
    if (!i_loop_mode) begin
      if (cl) begin
        sb_q.delete();
      end else if (!ld) begin
        can_wr = sb_q.size() < 16;
        if (rd && sb_q.size() > 0) begin
          chk("rdata", o_rdata, sb_q[0]);
          void'(sb_q.pop_front());
        end
        if (wr && can_wr) sb_q.push_back(d);
      end
    end
    @(posedge i_clk);
    #1;
    i_write    = 1'b0;
    i_read     = 1'b0;
    i_err_clr  = 1'b0;
    i_clr      = 1'b0;
    i_load_ptr = 1'b0;
  endtask

  initial begin
    checks      = 0;
    fails       = 0;
    i_rst_n     = 1'b0;
    i_clr       = 1'b0;
    i_loop_mode = 1'b0;
    i_load_ptr  = 1'b0;
    i_start_ptr = '0;
    i_stop_ptr  = '0;
    i_af_thresh = 5'd12;
    i_ae_thresh = 5'd3;
    i_write     = 1'b0;
    i_wdata     = '0;
    i_read      = 1'b0;
    i_err_clr   = 1'b0;

    //              wr rd ec cl lvl full en af ae ov ud
    vecs[0] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[1] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[2] = '{1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0};
    vecs[3] = '{1, 0, 0, 0, 2, 0, 1, 0, 1, 0, 0};
    vecs[4] = '{1, 0, 0, 0, 3, 0, 1, 0, 1, 0, 0};
    vecs[5] = '{1, 0, 0, 0, 4, 0, 1, 0, 0, 0, 0};
    vecs[6] = '{1, 1, 0, 0, 4, 0, 1, 0, 0, 0, 0};
    vecs[7] = '{0, 1, 0, 0, 3, 0, 1, 0, 1, 0, 0};
    vecs[8] = '{1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0};

    loop_exp = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0, 32'hA1};
    wrap_exp = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB0};

    #3;
    chk_flags("reset", 0, 0, 0, 0, 1, 0, 0);
    #9;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].wr, vecs[i].rd, 32'h100 + 32'(i), vecs[i].ec, vecs[i].cl, 1'b0);
      chk_flags($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].full, vecs[i].en,
                vecs[i].af, vecs[i].ae, vecs[i].ov, vecs[i].ud);
    end

    // Fill to full; almost-full rises on the twelfth word.
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 32'(k), 1'b0, 1'b0, 1'b0);
      chk($sformatf("fill%0d.level", k), 32'(o_level), 32'(k + 1));
      chk($sformatf("fill%0d.full", k), 32'(o_full), 32'(k == 15));
      chk($sformatf("fill%0d.afull", k), 32'(o_afull), 32'(k >= 11));
    end
    step(1'b1, 1'b0, 32'd99, 1'b0, 1'b0, 1'b0);
    chk_flags("ovf", 16, 1, 1, 1, 0, 1, 0);
    chk("ovf.head", o_rdata, 32'd0);

    // Read+write on full: read wins, write rejected.
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("errclr.overflow", 32'(o_overflow), 32'd0);
    step(1'b1, 1'b1, 32'd77, 1'b0, 1'b0, 1'b0);
    chk_flags("rw_full", 15, 0, 1, 1, 0, 1, 0);

    for (int k = 1; k <= 15; k++) begin
      step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("drain%0d.aempty", k), 32'(o_aempty), 32'((15 - k) <= 3));
      chk($sformatf("drain%0d.afull", k), 32'(o_afull), 32'((15 - k) >= 12));
    end
    chk_flags("drained", 0, 0, 0, 0, 1, 1, 0);

    // Underflow leaves pointers alone; next write lands at the head.
    step(1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    chk_flags("udf", 0, 0, 0, 0, 1, 0, 1);
    step(1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0);
    chk("udf.head", o_rdata, 32'h55);
    chk_flags("udf_wr", 1, 0, 1, 0, 1, 0, 1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("udf.clr", 32'(o_underflow), 32'd0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);

    // Loop window 2..5 replay.
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'hF0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hF1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'hA0 + 32'(k), 1'b0, 1'b0, 1'b0);
    i_loop_mode = 1'b1;
    i_start_ptr = 4'd2;
    i_stop_ptr  = 4'd5;
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("loop%0d.rdata", k), o_rdata, loop_exp[k]);
      step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    end
    chk_flags("loop", 0, 0, 1, 0, 0, 0, 0);

    // Window 14..1 wraps through address 0.
    i_start_ptr = 4'd14;
    i_stop_ptr  = 4'd1;
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'hB0 + 32'(k), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hEE, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("wrap%0d.rdata", k), o_rdata, wrap_exp[k]);
      step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    end
    chk_flags("wrap", 0, 0, 1, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a fill.
    i_loop_mode = 1'b0;
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 32'h200 + 32'(k), 1'b0, 1'b0, 1'b0);
    chk_flags("prerst", 5, 0, 1, 0, 0, 0, 1);
    i_rst_n = 1'b0;
    #1;
    chk_flags("midrst", 0, 0, 0, 0, 1, 0, 0);
    sb_q.delete();
    #2;
    i_rst_n = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk_flags("postrst", 0, 0, 0, 0, 1, 0, 0);
    step(1'b1, 1'b0, 32'h321, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    chk_flags("final", 0, 0, 0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ddr_sync_fifo_loop.md
DDR_SYNC_FIFO_LOOP -- requirements
Module: ddr_sync_fifo_loop

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, at least 4.
REQ-003 SHALL have parameter AWIDTH, default $clog2(DEPTH), address width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 i_clk  input  1  sole clock; all state on rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_clr  input  1  synchronous clear of pointers and error flags.
REQ-008 i_loop_mode  input  1  1 = replay window [start,stop]; 0 = normal FIFO.
REQ-009 i_load_ptr  input  1  load both pointers with i_start_ptr.
REQ-010 i_start_ptr / i_stop_ptr  input  AWIDTH each  loop window bounds.
REQ-011 i_af_thresh / i_ae_thresh  input  AWIDTH+1 each  almost-full / almost-empty levels.
REQ-012 i_write, i_wdata  input  1, WIDTH  write request and data.
REQ-013 i_read  input  1  read request; pops the current o_rdata.
REQ-014 o_rdata  output  WIDTH  show-ahead head entry.
REQ-015 o_full, o_afull, o_empty_n, o_aempty  output  1 each  status flags.
REQ-016 o_level  output  AWIDTH+1  occupancy.
REQ-017 o_overflow, o_underflow  output  1 each  sticky error flags.
REQ-018 i_err_clr  input  1  clears the sticky flags.

Function
REQ-019 Write and read pointers SHALL be AWIDTH+1-bit binary; memory address = low AWIDTH bits.
REQ-020 o_level SHALL equal (wptr - rptr) mod 2^(AWIDTH+1); o_full = (o_level == DEPTH); o_empty_n = (o_level != 0).
REQ-021 Normal mode: a write SHALL be accepted iff i_write & ~o_full; a read iff i_read & o_empty_n.
REQ-022 Simultaneous accepted read and write SHALL leave o_level unchanged; a write to a full FIFO is rejected even if a read occurs in the same cycle.
REQ-023 Written data SHALL appear on o_rdata and raise o_empty_n the cycle after the write edge (1-cycle latency) when the FIFO was empty.
REQ-024 A rejected write SHALL set o_overflow; a rejected read SHALL set o_underflow; both set on the next edge and hold until i_err_clr, i_clr or reset.
REQ-025 o_afull = (o_level >= i_af_thresh); o_aempty = (o_level <= i_ae_thresh); all flags combinational from registered state.
REQ-026 Loop mode: each pointer SHALL advance on its request and reload {1'b0,i_start_ptr} when its address equals i_stop_ptr; advance is modulo DEPTH otherwise, so a stop below start wraps through 0.
REQ-027 Loop mode: o_full = 0, o_empty_n = 1, o_afull = 0, o_aempty = 0, o_level = 0; no error flag SHALL set.
REQ-028 Priority per edge: i_clr > i_load_ptr > read/write.
REQ-029 i_load_ptr SHALL set both pointers to {1'b0,i_start_ptr} and ignore same-cycle read and write.
REQ-030 i_clr SHALL zero the pointers and the error flags; memory contents are unchanged.
REQ-031 Changing i_loop_mode SHALL take effect on the next edge without moving the pointers.

Reset
REQ-032 On i_rst_n low, pointers and sticky flags SHALL be 0 immediately: o_empty_n = 0, o_full = 0, o_level = 0, o_aempty = 1.
REQ-033 Memory SHALL NOT be reset; o_rdata is undefined while o_empty_n = 0 in normal mode.
REQ-034 Reset deassertion SHALL be synchronised externally; the block adds no scan-reset logic of its own.

Structure
REQ-035 Pointer logic SHALL be one sub-module, ddr_fifo_loop_ptr (increment, loop wrap, load, clear), instantiated twice.
REQ-036 DDR_FIFO_MIN_DEPTH (4) SHALL live in ddr_global_pkg; the block has no local typedefs.
REQ-037 Storage SHALL be a flip-flop register file written on i_clk.

Verification
REQ-038 DEPTH=16, write 16 words 0..15 -> o_full=1 after the 16th, o_level=16; 17th write -> o_overflow=1 and data unchanged.
REQ-039 From full, read and write together -> read accepted, write rejected, o_level=15, o_overflow=1.
REQ-040 Empty FIFO, i_read=1 -> o_underflow=1 and pointers unchanged; i_err_clr -> flag 0 next cycle.
REQ-041 Load A0..A3 at 2..5, loop_mode=1, start=2, stop=5, load_ptr, read 10 times -> A0 A1 A2 A3 A0 A1 A2 A3 A0 A1.
REQ-042 start=14, stop=1 in loop mode -> read addresses 14,15,0,1,14; level=0, no error flags.
REQ-043 i_af_thresh=12, i_ae_thresh=3; fill to 12 -> o_afull rises on the 12th write; drain to 3 -> o_aempty=1; i_rst_n pulse mid-fill -> all flags at their reset values.
